// File: rtl/base11_digit_seq_pkg.sv
// base11_digit_seq_pkg: shared constants and FSM state type for the base-11 digit sequencer
package base11_digit_seq_pkg;
    localparam int RADIX      = 11;
    localparam int MAX_DIGITS = 10;
    localparam int DIGIT_W    = 4;
    typedef enum logic [1:0] {IDLE, DIV, WAIT, EMIT} state_t;
endpackage

// File: rtl/base11_digit_seq_div.sv
// div_32_11: combinational divide of a 32-bit operand by the radix, quotient fits in 29 bits
module div_32_11
    import base11_digit_seq_pkg::*;
(
    input  logic [31:0]        x,
    output logic [28:0]        q,
    output logic [DIGIT_W-1:0] r
);
    assign q = 29'(x / 32'(RADIX));
    assign r = DIGIT_W'(x % 32'(RADIX));
endmodule

// File: rtl/base11_digit_seq.sv
// base11_digit_seq: streams the base-11 digits of a 32-bit operand, least significant first
module base11_digit_seq
    import base11_digit_seq_pkg::*;
#(
    parameter int DIV_PIPE = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [31:0]        in_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [DIGIT_W-1:0] out_digit,
    output logic [3:0]         out_index,
    output logic               out_last
);
    state_t state, state_d;
    logic [31:0] acc;
    logic [3:0] idx;
    logic [DIGIT_W-1:0] digit, r, r_s;
    logic [28:0] q, q_s;
    logic last, load;
    div_32_11 u_div (.x(acc), .q(q), .r(r));
    generate
        if (DIV_PIPE != 0) begin : g_pipe
            always_ff @(posedge clk) begin
                if (rst) begin
                    q_s <= '0;
                    r_s <= '0;
                end else if (state == DIV) begin
                    q_s <= q;
                    r_s <= r;
                end
            end
        end else begin : g_comb
            assign q_s = q;
            assign r_s = r;
        end
    endgenerate
    // the digit update happens where the quotient/remainder are final: DIV, or WAIT when piped
    assign load = state == ((DIV_PIPE != 0) ? WAIT : DIV);
    always_comb begin
        state_d = (state == IDLE && in_valid) ? DIV :
                  (state == DIV) ? ((DIV_PIPE != 0) ? WAIT : EMIT) :
                  (state == WAIT) ? EMIT :
                  (state == EMIT && out_ready) ? (last ? IDLE : DIV) : state;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            acc   <= '0;
            idx   <= '0;
            digit <= '0;
            last  <= 1'b0;
        end else begin
            state <= state_d;
            if (state == IDLE && in_valid) begin
                acc <= in_data;
                idx <= '0;
            end
            if (load) begin
                digit <= r_s;
                acc   <= {3'b0, q_s};
                last  <= q_s == '0;
                assert (r_s < DIGIT_W'(RADIX));
            end
            if (state == EMIT && out_ready && !last) idx <= idx + 4'd1;
            assert (idx < 4'(MAX_DIGITS));
        end
    end
    assign in_ready  = !rst && state == IDLE;
    assign out_valid = !rst && state == EMIT;
    assign out_digit = digit;
    assign out_index = idx;
    assign out_last  = last;
endmodule

// File: tb/tb_base11_digit_seq.sv
// tb_base11_digit_seq: randomized self-checking bench driving one instance per DIV_PIPE value
module tb_base11_digit_seq;
    logic clk = 0;
    logic rst = 1;
    logic iv[2], ir[2], ov[2], orr[2], olast[2];
    logic [31:0] data[2];
    logic [3:0] odig[2], oidx[2];
    int tests = 0;
    int fails = 0;
    int exp_q[$];

    always #5 clk = ~clk;

    base11_digit_seq #(.DIV_PIPE(0)) dut0 (
        .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]), .in_data(data[0]),
        .out_valid(ov[0]), .out_ready(orr[0]), .out_digit(odig[0]), .out_index(oidx[0]), .out_last(olast[0])
    );
    base11_digit_seq #(.DIV_PIPE(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]), .in_data(data[1]),
        .out_valid(ov[1]), .out_ready(orr[1]), .out_digit(odig[1]), .out_index(oidx[1]), .out_last(olast[1])
    );

    // reference: digits of v in base 11, least significant first
    function automatic void fill_model(input logic [31:0] v);
        longint unsigned t;
        exp_q.delete();
        t = longint'(v);
        do begin
            exp_q.push_back(int'(t % 11));
            t = t / 11;
        end while (t != 0);
    endfunction

    // called at a negedge; leaves in_valid/in_data at nv/nd once the operand is accepted
    task automatic convert(input int d, input logic [31:0] v, input bit bp, input bit nv, input logic [31:0] nd);
        int n, cyc, got, last_cyc;
        bit stall, first, rdy;
        logic [3:0] hd, hi;
        logic hl;
        fill_model(v);
        iv[d] = 1;
        data[d] = v;
        n = 0;
        while (ir[d] !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        tests++;
        if (ir[d] !== 1'b1) begin
            fails++;
            $display("FAIL accept d=%0d v=%0d: in_ready=%b, required 1", d, v, ir[d]);
            iv[d] = 0;
            return;
        end
        @(negedge clk);
        iv[d] = nv;
        data[d] = nd;
        cyc = 1; got = 0; last_cyc = 0; stall = 0; first = 1;
        hd = 0; hi = 0; hl = 0;
        while (got < exp_q.size() && cyc < 300) begin
            tests++;
            if (ir[d] !== 1'b0) begin
                fails++;
                $display("FAIL busy_ready d=%0d v=%0d cyc=%0d: in_ready=%b, required 0", d, v, cyc, ir[d]);
            end
            if (stall) begin
                tests++;
                if (ov[d] !== 1'b1 || odig[d] !== hd || oidx[d] !== hi || olast[d] !== hl) begin
                    fails++;
                    $display("FAIL stall_hold d=%0d: got v=%b dig=%0d idx=%0d last=%b, required 1/%0d/%0d/%b",
                             d, ov[d], odig[d], oidx[d], olast[d], hd, hi, hl);
                end
            end
            rdy = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            orr[d] = rdy;
            stall = 0;
            if (ov[d] === 1'b1) begin
                if (first) begin
                    first = 0;
                    tests++;
                    if (cyc != 2 + d) begin
                        fails++;
                        $display("FAIL latency d=%0d v=%0d: first digit at cycle %0d, required %0d", d, v, cyc, 2 + d);
                    end
                end
                if (rdy) begin
                    tests++;
                    if (odig[d] !== 4'(exp_q[got]) || oidx[d] !== 4'(got) || olast[d] !== (got == exp_q.size() - 1)) begin
                        fails++;
                        $display("FAIL digit d=%0d v=%0d n=%0d: got dig=%0d idx=%0d last=%b, required dig=%0d idx=%0d last=%b",
                                 d, v, got, odig[d], oidx[d], olast[d], exp_q[got], got, got == exp_q.size() - 1);
                    end
                    if (!bp && got > 0) begin
                        tests++;
                        if (cyc - last_cyc != 2 + d) begin
                            fails++;
                            $display("FAIL period d=%0d v=%0d: %0d cycles, required %0d", d, v, cyc - last_cyc, 2 + d);
                        end
                    end
                    last_cyc = cyc;
                    got++;
                end else begin
                    stall = 1;
                    hd = odig[d]; hi = oidx[d]; hl = olast[d];
                end
            end
            @(negedge clk);
            cyc++;
        end
        orr[d] = 0;
        tests++;
        if (got != exp_q.size()) begin
            fails++;
            $display("FAIL digit_count d=%0d v=%0d: got %0d digits, required %0d", d, v, got, exp_q.size());
        end
        tests++;
        if (ov[d] !== 1'b0 || ir[d] !== 1'b1) begin
            fails++;
            $display("FAIL end_state d=%0d v=%0d: out_valid=%b in_ready=%b, required 0/1", d, v, ov[d], ir[d]);
        end
    endtask

    task automatic test_reset();
        rst = 1;
        repeat (2) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            tests++;
            if (ov[d] !== 0 || ir[d] !== 0 || odig[d] !== 0 || oidx[d] !== 0 || olast[d] !== 0) begin
                fails++;
                $display("FAIL reset_hold d=%0d: v=%b r=%b dig=%0d idx=%0d last=%b, required all 0",
                         d, ov[d], ir[d], odig[d], oidx[d], olast[d]);
            end
        end
        rst = 0;
        #1;
        for (int d = 0; d < 2; d++) begin
            tests++;
            if (ir[d] !== 1'b1 || ov[d] !== 1'b0) begin
                fails++;
                $display("FAIL reset_release d=%0d: in_ready=%b out_valid=%b, required 1/0", d, ir[d], ov[d]);
            end
        end
    endtask

    task automatic test_boundaries(input int d);
        convert(d, 32'd0, 0, 0, 0);
        convert(d, 32'd10, 0, 0, 0);
        convert(d, 32'd11, 0, 0, 0);
        convert(d, 32'hFFFF_FFFF, 0, 0, 0);
    endtask

    task automatic test_random(input int d);
        for (int i = 0; i < 6; i++) convert(d, $urandom >> $urandom_range(0, 31), 0, 0, 0);
    endtask

    task automatic test_backpressure(input int d);
        convert(d, 32'd4294967295, 1, 0, 0);
        for (int i = 0; i < 3; i++) convert(d, $urandom, 1, 0, 0);
    endtask

    task automatic test_mid_reset(input int d);
        int n;
        iv[d] = 1;
        data[d] = 32'hFFFF_FFFF;
        n = 0;
        while (ir[d] !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        iv[d] = 0;
        orr[d] = 1;
        n = 0;
        while (!(ov[d] === 1'b1 && oidx[d] === 4'd4) && n < 100) begin
            @(negedge clk);
            n++;
        end
        tests++;
        if (!(ov[d] === 1'b1 && oidx[d] === 4'd4)) begin
            fails++;
            $display("FAIL mid_reach d=%0d: out_valid=%b idx=%0d, required 1/4", d, ov[d], oidx[d]);
        end
        orr[d] = 0;
        rst = 1;
        @(negedge clk);
        tests++;
        if (ov[d] !== 1'b0) begin
            fails++;
            $display("FAIL mid_reset d=%0d: out_valid=%b, required 0", d, ov[d]);
        end
        rst = 0;
        #1;
        tests++;
        if (ir[d] !== 1'b1 || ov[d] !== 1'b0 || odig[d] !== 0 || oidx[d] !== 0 || olast[d] !== 0) begin
            fails++;
            $display("FAIL mid_after d=%0d: r=%b v=%b dig=%0d idx=%0d last=%b, required 1/0/0/0/0",
                     d, ir[d], ov[d], odig[d], oidx[d], olast[d]);
        end
        convert(d, 32'd121, 0, 0, 0);
    endtask

    task automatic test_back_to_back(input int d);
        convert(d, 32'd0, 0, 1, 32'd11);
        convert(d, 32'd11, 0, 0, 0);
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            iv[d] = 0;
            orr[d] = 0;
            data[d] = 0;
        end
        test_reset();
        for (int d = 0; d < 2; d++) begin
            test_boundaries(d);
            test_random(d);
            test_backpressure(d);
            test_mid_reset(d);
            test_back_to_back(d);
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
